ttt_game_controller: RTL and testbench
======================================

# ttt_game_controller

Turn sequencer for the FPGA tic-tac-toe board. It takes debounced single-cycle button pulses, moves a cursor over the 3x3 grid and alternates players. It validates placements against its own 9-cell board record, emits a one-cycle select pulse to the addressed cell's drawing logic, and detects win/draw. It sits between the input conditioning (debounce/edge-detect) and the per-cell display modules, which receive `player`, `row`, `col` and `select` from it.

## Interface
- No parameters (grid fixed at 3x3).
- `clock` in 1: system clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `up`, `down`, `left`, `right` in 1 each: cursor move pulses, one cycle wide.
- `place` in 1: place-mark pulse, one cycle wide.
- `new_game` in 1: restart pulse, one cycle wide.
- `row` out 2: cursor row, 0..2, top = 0.
- `col` out 2: cursor column, 0..2, left = 0.
- `player` out 1: side to move; 0 = X, 1 = O.
- `select` out 9: one-hot cell strobe; bit k = row*3+col.
- `board` out 18: cell k at bits [2k+1:2k]; 00 empty, 01 X, 10 O, 11 never produced.
- `illegal` out 1: one-cycle pulse on place to an occupied cell.
- `game_over` out 1: high in WIN or DRAW.
- `winner` out 1: winning player; valid only while `draw` = 0 and `game_over` = 1.
- `draw` out 1: high in DRAW.

## Operation
- States: PLAY, CHECK, WIN, DRAW.
- Reset values: state PLAY; row = col = 0; player = 0; board = 0; select = 0; illegal = 0; game_over = 0; winner = 0; draw = 0.
- PLAY, cursor movement:
  - `up` gives row-1 and `down` gives row+1. Both saturate at 0 and 2; no wrap.
  - `left` and `right` act on col the same way.
  - Multiple move pulses in one cycle: only the highest-priority one applies. Priority: up > down > left > right.
- PLAY, `place`:
  - Takes precedence over any same-cycle move pulse; the move is dropped.
  - Cursor cell empty: write mark (player 0 writes 01, player 1 writes 10), pulse `select[row*3+col]`, go to CHECK.
  - Cursor cell occupied: board unchanged, pulse `illegal`, stay in PLAY, player unchanged.
- CHECK (exactly one cycle): evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) for the current player's mark. Priority:
  - Any line complete: go to WIN, `winner` <= player.
  - Else all 9 cells non-empty: go to DRAW.
  - Else toggle player, go to PLAY.
  - Moves, `place` and `new_game` in CHECK are ignored.
- WIN/DRAW: moves and `place` are ignored; `illegal` is never pulsed. Cursor holds.
- `new_game` in PLAY, WIN or DRAW: next edge clears board, row, col, player, winner and draw, and enters PLAY. It takes precedence over same-cycle `place` and moves.
- `select` and `illegal` are zero in every cycle except the single pulse cycle.
- `row`, `col`, `player` are registered and stable during the `select` pulse, so cell modules latch correct coordinates and mark.

## Timing
- Move pulse sampled at edge N: row/col updated after edge N (1-cycle latency).
- `place` sampled at edge N, cell empty:
  - After edge N: `board` updated, `select` high for cycle N..N+1, state CHECK.
  - After edge N+1: `game_over`/`winner`/`draw` valid, or player toggled.
  - Outcome latency: 2 edges.
- `place` at edge N, cell occupied: `illegal` high for cycle N..N+1 only.
- Back-to-back `place` at N and N+1: the second lands in CHECK and is ignored. The bench must space places at least 2 cycles apart.
- Reset assertion mid-CHECK or mid-pulse: outputs go to reset values immediately (asynchronous), with no completion of the pending transition.
- Reset release: first active edge is processed normally; inputs sampled that edge are honoured.

## Test plan
- Reset, then 3x `down` and 3x `right`: row = 2, col = 2 (saturation); one more `up`: row = 1.
- `up` and `left` pulsed together at (1,1): row = 0, col = 1. `place` with `right` at (0,1): mark 01 at k=1, `select` = 9'b000000010 for one cycle, col stays 1; two cycles later player = 1.
- X plays k = 0, 1, 2 and O plays k = 3, 4, alternating: after X's third place, `game_over` = 1, `winner` = 0 two edges later. A further `place` changes nothing.
- `place` on occupied k=4: `illegal` pulses one cycle, `board` and player unchanged, `select` = 0.
- Fill the board with no line, in order X0, O1, X2, O4, X3, O5, X7, O6, X8: `draw` = 1 and `game_over` = 1 after the final place plus 2 edges. Then `new_game`: board = 0, player = 0, row = col = 0, game_over = 0.
- Assert `reset` low asynchronously in the CHECK cycle after a winning place: `game_over` never rises, board = 0 immediately.

Source files
------------

// File: rtl/ttt_game_controller.sv
// Tic-tac-toe turn sequencer: cursor movement, placement validation,
// per-cell select strobe and win/draw detection over a 3x3 board.
module ttt_game_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        place,
  input  logic        new_game,
  output logic [1:0]  row,
  output logic [1:0]  col,
  output logic        player,
  output logic [8:0]  select,
  output logic [17:0] board,
  output logic        illegal,
  output logic        game_over,
  output logic        winner,
  output logic        draw
);

  localparam int unsigned CELLS   = 9;
  localparam int unsigned BOARD_W = 2 * CELLS;

  typedef enum logic [1:0] {PLAY, CHECK, WIN, DRAW} state_t;

  state_t               state, state_d;
  logic [1:0]           row_d, col_d;
  logic                 player_d, illegal_d, game_over_d, winner_d, draw_d;
  logic [CELLS-1:0]     select_d;
  logic [BOARD_W-1:0]   board_d;
  logic [3:0]           cur_k;
  logic [1:0]           cur_cell;
  logic [1:0]           mark;
  logic                 line_done;
  logic                 board_full;

  // True when any of the 8 lines is filled entirely with mark m
  function automatic logic has_line(input logic [BOARD_W-1:0] b, input logic [1:0] m);
    logic [CELLS-1:0] o;
    for (int i = 0; i < CELLS; i++) o[i] = (b[2*i +: 2] == m);
    return (o[0] & o[1] & o[2]) | (o[3] & o[4] & o[5]) | (o[6] & o[7] & o[8]) |
           (o[0] & o[3] & o[6]) | (o[1] & o[4] & o[7]) | (o[2] & o[5] & o[8]) |
           (o[0] & o[4] & o[8]) | (o[2] & o[4] & o[6]);
  endfunction

  // Board decode: cursor cell contents, current mark, line and full detection
  always_comb begin
    cur_k      = {2'b00, row} * 4'd3 + {2'b00, col};
    mark       = player ? 2'b10 : 2'b01;
    cur_cell   = 2'b00;
    board_full = 1'b1;
    for (int i = 0; i < CELLS; i++) begin
      if (4'(i) == cur_k) cur_cell = board[2*i +: 2];
      if (board[2*i +: 2] == 2'b00) board_full = 1'b0;
    end
    line_done = has_line(board, mark);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    row_d       = row;
    col_d       = col;
    player_d    = player;
    select_d    = '0;
    board_d     = board;
    illegal_d   = 1'b0;
    game_over_d = game_over;
    winner_d    = winner;
    draw_d      = draw;
    case (state)
      PLAY: begin
        if (new_game) begin
          state_d = PLAY; board_d = '0; row_d = 2'd0; col_d = 2'd0;
          player_d = 1'b0; winner_d = 1'b0; draw_d = 1'b0; game_over_d = 1'b0;
        end else if (place) begin
          if (cur_cell == 2'b00) begin
            for (int i = 0; i < CELLS; i++) begin
              if (4'(i) == cur_k) begin
                board_d[2*i +: 2] = mark;
                select_d[i]       = 1'b1;
              end
            end
            state_d = CHECK;
          end else begin
            illegal_d = 1'b1;
          end
        end else if (up) begin
          if (row != 2'd0) row_d = row - 2'd1;
        end else if (down) begin
          if (row != 2'd2) row_d = row + 2'd1;
        end else if (left) begin
          if (col != 2'd0) col_d = col - 2'd1;
        end else if (right) begin
          if (col != 2'd2) col_d = col + 2'd1;
        end
      end
      CHECK: begin
        if (line_done) begin
          state_d = WIN; game_over_d = 1'b1; winner_d = player;
        end else if (board_full) begin
          state_d = DRAW; game_over_d = 1'b1; draw_d = 1'b1;
        end else begin
          state_d = PLAY; player_d = ~player;
        end
      end
      WIN, DRAW: begin
        if (new_game) begin
          state_d = PLAY; board_d = '0; row_d = 2'd0; col_d = 2'd0;
          player_d = 1'b0; winner_d = 1'b0; draw_d = 1'b0; game_over_d = 1'b0;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= PLAY;
      row       <= 2'd0;
      col       <= 2'd0;
      player    <= 1'b0;
      select    <= '0;
      board     <= '0;
      illegal   <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      draw      <= 1'b0;
    end else begin
      state     <= state_d;
      row       <= row_d;
      col       <= col_d;
      player    <= player_d;
      select    <= select_d;
      board     <= board_d;
      illegal   <= illegal_d;
      game_over <= game_over_d;
      winner    <= winner_d;
      draw      <= draw_d;
    end
  end

endmodule

// File: tb/tb_ttt_game_controller.sv
// Bench for ttt_game_controller: game-level reference model with per-cycle
// comparison, directed scenarios with literal expectations, random play.
module tb_ttt_game_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic        place = 1'b0, new_game = 1'b0;
  logic [1:0]  row, col;
  logic        player, illegal, game_over, winner, draw;
  logic [8:0]  select;
  logic [17:0] board;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  ttt_game_controller dut (
    .clock(clock), .reset(reset), .up(up), .down(down), .left(left),
    .right(right), .place(place), .new_game(new_game), .row(row), .col(col),
    .player(player), .select(select), .board(board), .illegal(illegal),
    .game_over(game_over), .winner(winner), .draw(draw)
  );

  always #5 clock = ~clock;

  // Reference model: cells hold 0 empty, 1 X, 2 O
  int m_cells[9] = '{default: 0};
  int m_row = 0, m_col = 0, m_player = 0, m_over = 0, m_winner = 0, m_draw = 0;
  int m_pend = 0, m_sel = -1, m_ill = 0;

  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic bit wins(input int b[9], input int m);
    for (int l = 0; l < 8; l++)
      if (b[lines[l][0]] == m && b[lines[l][1]] == m && b[lines[l][2]] == m) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit full(input int b[9]);
    for (int i = 0; i < 9; i++) if (b[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [17:0] pack(input int b[9]);
    logic [17:0] v = '0;
    for (int i = 0; i < 9; i++) v[2*i +: 2] = 2'(b[i]);
    return v;
  endfunction

  // Model advances one game step per clock edge
  always @(posedge clock or negedge reset) begin
    int c[9];
    int r, cc, p, ov, wn, dr, pend, sel, ill, k;
    if (!reset) begin
      m_cells <= '{default: 0};
      m_row <= 0; m_col <= 0; m_player <= 0; m_over <= 0; m_winner <= 0;
      m_draw <= 0; m_pend <= 0; m_sel <= -1; m_ill <= 0;
    end else begin
      c = m_cells; r = m_row; cc = m_col; p = m_player; ov = m_over;
      wn = m_winner; dr = m_draw; pend = m_pend; sel = -1; ill = 0;
      if (pend != 0) begin
        pend = 0;
        if (wins(c, p + 1)) begin ov = 1; wn = p; end
        else if (full(c)) begin ov = 1; dr = 1; end
        else p = 1 - p;
      end else if (new_game) begin
        c = '{default: 0}; r = 0; cc = 0; p = 0; ov = 0; wn = 0; dr = 0;
      end else if (ov == 0) begin
        if (place) begin
          k = r * 3 + cc;
          if (c[k] == 0) begin c[k] = p + 1; sel = k; pend = 1; end
          else ill = 1;
        end
        else if (up)    r  = (r  > 0) ? r - 1  : 0;
        else if (down)  r  = (r  < 2) ? r + 1  : 2;
        else if (left)  cc = (cc > 0) ? cc - 1 : 0;
        else if (right) cc = (cc < 2) ? cc + 1 : 2;
      end
      m_cells <= c; m_row <= r; m_col <= cc; m_player <= p; m_over <= ov;
      m_winner <= wn; m_draw <= dr; m_pend <= pend; m_sel <= sel; m_ill <= ill;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clock) begin
    if (chk_en) begin
      check("m_row",       32'(row),       32'(m_row));
      check("m_col",       32'(col),       32'(m_col));
      check("m_player",    32'(player),    32'(m_player));
      check("m_board",     32'(board),     32'(pack(m_cells)));
      check("m_select",    32'(select),    (m_sel < 0) ? 32'd0 : (32'd1 << m_sel));
      check("m_illegal",   32'(illegal),   32'(m_ill));
      check("m_game_over", 32'(game_over), 32'(m_over));
      check("m_winner",    32'(winner),    32'(m_winner));
      check("m_draw",      32'(draw),      32'(m_draw));
    end
  end

  // One cycle of input pulses: {up,down,left,right,place,new_game}
  task automatic step(input logic [5:0] v);
    {up, down, left, right, place, new_game} = v;
    @(posedge clock); #1;
    {up, down, left, right, place, new_game} = 6'b0;
  endtask

  task automatic goto(input int r, input int c);
    step(6'b100000); step(6'b100000); step(6'b001000); step(6'b001000);
    for (int i = 0; i < r; i++) step(6'b010000);
    for (int i = 0; i < c; i++) step(6'b000100);
  endtask

  task automatic place_at(input int k);
    goto(k / 3, k % 3);
    step(6'b000010);
    step(6'b000000);
  endtask

  initial begin
    logic [5:0] v;
    bit cool;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_row", 32'(row), 0);           check("rst_col", 32'(col), 0);
    check("rst_player", 32'(player), 0);     check("rst_board", 32'(board), 0);
    check("rst_select", 32'(select), 0);     check("rst_over", 32'(game_over), 0);
    chk_en = 1'b1;
    reset = 1'b1;

    // Saturation and move priority
    repeat (3) step(6'b010000);
    repeat (3) step(6'b000100);
    check("sat_row", 32'(row), 2);           check("sat_col", 32'(col), 2);
    step(6'b100000);
    check("up_row", 32'(row), 1);
    step(6'b001000);
    step(6'b101000);
    check("prio_row", 32'(row), 0);          check("prio_col", 32'(col), 1);
    step(6'b000110);
    check("pl_board", 32'(board), 32'h4);    check("pl_select", 32'(select), 32'h2);
    check("pl_col", 32'(col), 1);
    step(6'b000000);
    check("pl_select_off", 32'(select), 0);  check("pl_player", 32'(player), 1);

    // X wins on the top row
    step(6'b000001);
    check("ng_board", 32'(board), 0);        check("ng_player", 32'(player), 0);
    place_at(0); place_at(3); place_at(1); place_at(4); place_at(2);
    check("win_over", 32'(game_over), 1);    check("win_winner", 32'(winner), 0);
    check("win_draw", 32'(draw), 0);         check("win_board", 32'(board), 32'h295);
    goto(2, 2);
    step(6'b000010);
    check("post_board", 32'(board), 32'h295); check("post_select", 32'(select), 0);
    check("post_illegal", 32'(illegal), 0);

    // Placement on an occupied cell
    step(6'b000001);
    place_at(4);
    goto(1, 1);
    step(6'b000010);
    check("ill_pulse", 32'(illegal), 1);     check("ill_select", 32'(select), 0);
    check("ill_board", 32'(board), 32'h100); check("ill_player", 32'(player), 1);
    step(6'b000000);
    check("ill_off", 32'(illegal), 0);

    // Full board with no line
    step(6'b000001);
    place_at(0); place_at(1); place_at(2); place_at(4); place_at(3);
    place_at(5); place_at(7); place_at(6); place_at(8);
    check("draw_flag", 32'(draw), 1);        check("draw_over", 32'(game_over), 1);
    check("draw_board", 32'(board), 32'h16A59);
    step(6'b000001);
    check("ng2_board", 32'(board), 0);       check("ng2_player", 32'(player), 0);
    check("ng2_row", 32'(row), 0);           check("ng2_col", 32'(col), 0);
    check("ng2_over", 32'(game_over), 0);

    // Asynchronous reset in the CHECK cycle after a winning place
    place_at(0); place_at(3); place_at(1); place_at(4);
    goto(0, 2);
    step(6'b000010);
    reset = 1'b0;
    #1;
    check("ar_board", 32'(board), 0);        check("ar_over", 32'(game_over), 0);
    check("ar_select", 32'(select), 0);
    @(posedge clock); #1;
    check("ar_over2", 32'(game_over), 0);
    reset = 1'b1;
    step(6'b000000);
    check("ar_over3", 32'(game_over), 0);    check("ar_player", 32'(player), 0);

    // Random play against the model
    cool = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      v[5] = ($urandom_range(0, 3) == 0);
      v[4] = ($urandom_range(0, 3) == 0);
      v[3] = ($urandom_range(0, 3) == 0);
      v[2] = ($urandom_range(0, 3) == 0);
      v[1] = !cool && ($urandom_range(0, 2) == 0);
      v[0] = ($urandom_range(0, 59) == 0);
      cool = v[1];
      step(v);
    end

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
